// File: rtl/vsource_switch_ctrl.sv
// ---------------------------------------------------------------------------
// vsource_switch_ctrl
//
// Frame-synchronous source controller for the PPU front end. Decides when
// the downstream video mux moves between live N64 video and the test pattern
// generator. A switch only lands on a vertical sync falling edge, after a
// programmable number of forced-black fields, so nothing downstream ever sees
// a torn field. If sync is lost the pending switch is taken at once.
//
// Ports
//   VCLK                in   video clock, the only clock
//   RST                 in   synchronous active-high reset
//   palmode             in   1 = PAL line timeout, 0 = NTSC line timeout
//   tp_req              in   level request: 1 = test pattern, 0 = live video
//   vdata_sync_valid_i  in   qualifies vdata_sync_i (no handshake; sampled
//                            only on cycles where it is 1)
//   vdata_sync_i[3:0]   in   {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
//   tp_en_o             out  mux select, 1 = test pattern path
//   blank_o             out  forces colour to zero downstream
//   busy_o              out  switch pending or blanking in progress
//   sync_lost_o         out  sync-loss flag
//   o_dbg_state[1:0]    out  current FSM state (0 STEADY, 1 ARM, 2 BLANK)
//
// All outputs are registered: a decision taken on input cycle n appears on
// the outputs right after the edge that closes cycle n.
// ---------------------------------------------------------------------------
module vsource_switch_ctrl #(
  parameter int BLANK_FIELDS  = 2,
  parameter int LINES_TO_NTSC = 280,
  parameter int LINES_TO_PAL  = 330,
  parameter int CYC_TO        = 8191
) (
  input  logic       VCLK,
  input  logic       RST,
  input  logic       palmode,
  input  logic       tp_req,
  input  logic       vdata_sync_valid_i,
  input  logic [3:0] vdata_sync_i,
  output logic       tp_en_o,
  output logic       blank_o,
  output logic       busy_o,
  output logic       sync_lost_o,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    ST_STEADY = 2'd0,
    ST_ARM    = 2'd1,
    ST_BLANK  = 2'd2
  } state_t;

  localparam logic [2:0]  FIELDS   = 3'(BLANK_FIELDS);
  localparam logic [8:0]  L_NTSC   = 9'(LINES_TO_NTSC);
  localparam logic [8:0]  L_PAL    = 9'(LINES_TO_PAL);
  localparam logic [12:0] CYC_LIM  = 13'(CYC_TO);
  localparam logic [8:0]  LINE_MAX = 9'h1FF;
  localparam logic [12:0] CYC_MAX  = 13'h1FFF;

  // Registers
  state_t      r_state;
  logic [2:0]  r_fcnt;
  logic        r_tp_en;
  logic        r_blank;
  logic        r_busy;
  logic        r_sync_lost;
  logic        r_prev_nvs;
  logic        r_prev_nhs;
  logic [8:0]  r_line_cnt;
  logic [12:0] r_cyc_cnt;

  // Combinational
  state_t      w_state_nxt;
  logic [2:0]  w_fcnt_nxt;
  logic        w_tp_en_nxt;
  logic        w_req_diff;
  logic        w_vs_fall;
  logic        w_hs_fall;
  logic [8:0]  w_line_nxt;
  logic [12:0] w_cyc_nxt;
  logic [8:0]  w_line_thr;
  logic        w_lost_set;
  logic        w_lost_clr;
  logic        w_unused_sync;

  // nCLAMP and nCSYNC are carried on the bus but not needed here.
  assign w_unused_sync = ^{vdata_sync_i[2], vdata_sync_i[0]};

  // Edges are only seen on valid cycles; the previous-value registers hold
  // across invalid cycles so an edge straddling them is detected late, not lost.
  assign w_vs_fall = vdata_sync_valid_i & r_prev_nvs & ~vdata_sync_i[3];
  assign w_hs_fall = vdata_sync_valid_i & r_prev_nhs & ~vdata_sync_i[1];

  // ---------------------------------------------------------------------
  // Sync monitor
  // ---------------------------------------------------------------------
  always_comb begin
    w_line_nxt = r_line_cnt;
    if (w_vs_fall) begin
      w_line_nxt = '0;
    end else if (w_hs_fall && (r_line_cnt != LINE_MAX)) begin
      w_line_nxt = r_line_cnt + 9'd1;
    end
  end

  always_comb begin
    w_cyc_nxt = r_cyc_cnt;
    if (w_hs_fall) begin
      w_cyc_nxt = '0;
    end else if (r_cyc_cnt != CYC_MAX) begin
      w_cyc_nxt = r_cyc_cnt + 13'd1;
    end
  end

  assign w_line_thr = palmode ? L_PAL : L_NTSC;

  // The flag is raised from the counter values being written this cycle so
  // it lands one edge after the offending hsync / timeout, not two.
  assign w_lost_set = (w_line_nxt >= w_line_thr) || (w_cyc_nxt >= CYC_LIM);
  assign w_lost_clr = w_vs_fall && (r_cyc_cnt < CYC_LIM);

  // ---------------------------------------------------------------------
  // Switch FSM: next state and next outputs
  // ---------------------------------------------------------------------
  assign w_req_diff = (tp_req != r_tp_en);

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_tp_en_nxt = r_tp_en;
    case (r_state)
      ST_STEADY: begin
        if (w_req_diff) begin
          w_state_nxt = ST_ARM;
        end
      end
      ST_ARM: begin
        // Cancel outranks both sync loss and the vsync boundary.
        if (!w_req_diff) begin
          w_state_nxt = ST_STEADY;
        end else if (r_sync_lost) begin
          w_tp_en_nxt = ~r_tp_en;
          w_state_nxt = ST_STEADY;
        end else if (w_vs_fall) begin
          if (FIELDS == 3'd0) begin
            w_tp_en_nxt = ~r_tp_en;
            w_state_nxt = ST_STEADY;
          end else begin
            w_fcnt_nxt  = FIELDS;
            w_state_nxt = ST_BLANK;
          end
        end
      end
      ST_BLANK: begin
        // A reverted request still finishes blanking; only the toggle is
        // suppressed, so the mux never changes on a non-boundary.
        if (r_sync_lost) begin
          if (w_req_diff) begin
            w_tp_en_nxt = ~r_tp_en;
          end
          w_fcnt_nxt  = '0;
          w_state_nxt = ST_STEADY;
        end else if (w_vs_fall) begin
          if (r_fcnt <= 3'd1) begin
            if (w_req_diff) begin
              w_tp_en_nxt = ~r_tp_en;
            end
            w_fcnt_nxt  = '0;
            w_state_nxt = ST_STEADY;
          end else begin
            w_fcnt_nxt = r_fcnt - 3'd1;
          end
        end
      end
      default: begin
        w_fcnt_nxt  = '0;
        w_state_nxt = ST_STEADY;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge VCLK) begin
    if (RST) begin
      r_state     <= ST_STEADY;
      r_fcnt      <= '0;
      r_tp_en     <= 1'b0;
      r_blank     <= 1'b0;
      r_busy      <= 1'b0;
      r_sync_lost <= 1'b0;
      r_prev_nvs  <= 1'b1;
      r_prev_nhs  <= 1'b1;
      r_line_cnt  <= '0;
      r_cyc_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fcnt     <= w_fcnt_nxt;
      // tp_en and blank update on the same edge, so the mux change and the
      // unblank coincide.
      r_tp_en    <= w_tp_en_nxt;
      r_blank    <= (w_state_nxt == ST_BLANK);
      r_busy     <= (w_state_nxt != ST_STEADY);
      r_line_cnt <= w_line_nxt;
      r_cyc_cnt  <= w_cyc_nxt;
      if (vdata_sync_valid_i) begin
        r_prev_nvs <= vdata_sync_i[3];
        r_prev_nhs <= vdata_sync_i[1];
      end
      if (w_lost_set) begin
        r_sync_lost <= 1'b1;
      end else if (w_lost_clr) begin
        r_sync_lost <= 1'b0;
      end
    end
  end

  assign tp_en_o     = r_tp_en;
  assign blank_o     = r_blank;
  assign busy_o      = r_busy;
  assign sync_lost_o = r_sync_lost;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vsource_switch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vsource_switch_ctrl
//
// Directed bench for vsource_switch_ctrl with default parameters.
// A small sync generator produces fields of 12 lines x 10 cycles: nHSYNC is
// low for columns 0-1 of every line, nVSYNC is low for field positions 5..14,
// so hsync and vsync falling edges never share a cycle. The bench keeps its
// own copy of the previous sync levels to know on which cycle each edge is
// seen. Outputs are compared 1 time unit after the rising edge, as the packed
// value {tp_en, blank, busy, sync_lost}.
// ---------------------------------------------------------------------------
module tb_vsource_switch_ctrl;

  localparam int LINE  = 10;
  localparam int FIELD = 120;

  // Clock / reset
  logic VCLK = 1'b0;
  always #5 VCLK = ~VCLK;

  logic       RST;
  logic       palmode;
  logic       tp_req;
  logic       vdata_sync_valid_i;
  logic [3:0] vdata_sync_i;
  logic       tp_en_o;
  logic       blank_o;
  logic       busy_o;
  logic       sync_lost_o;
  logic [1:0] o_dbg_state;

  vsource_switch_ctrl dut (
    .VCLK               (VCLK),
    .RST                (RST),
    .palmode            (palmode),
    .tp_req             (tp_req),
    .vdata_sync_valid_i (vdata_sync_valid_i),
    .vdata_sync_i       (vdata_sync_i),
    .tp_en_o            (tp_en_o),
    .blank_o            (blank_o),
    .busy_o             (busy_o),
    .sync_lost_o        (sync_lost_o),
    .o_dbg_state        (o_dbg_state)
  );

  // Scoreboard counters
  int checks   = 0;
  int failures = 0;

  // Generator state and bench-side edge model
  int   gpos  = 0;
  logic vs_on = 1'b1;
  logic hs_on = 1'b1;
  logic vmode = 1'b0;  // 1: every 4th cycle (pos%4==1) is invalid
  logic m_pv  = 1'b1;
  logic m_ph  = 1'b1;
  logic e_vs  = 1'b0;
  logic e_hs  = 1'b0;

  typedef struct {
    logic       v;
    logic [3:0] s;
    logic       req;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(input logic v, input logic [3:0] s,
                              input logic req, input logic [3:0] exp);
    vec_t r;
    r.v   = v;
    r.s   = s;
    r.req = req;
    r.exp = exp;
    return r;
  endfunction

  task automatic chk(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = {tp_en_o, blank_o, busy_o, sync_lost_o};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: {tp_en,blank,busy,lost} got %b expected %b at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: cycle bound expired at %0t", name, $time);
  endtask

  // Driver: apply one cycle of inputs, track edges, wait past the edge.
  task automatic drive(input logic v, input logic [3:0] s);
    vdata_sync_valid_i = v;
    vdata_sync_i       = s;
    if (RST) begin
      e_vs = 1'b0;
      e_hs = 1'b0;
      m_pv = 1'b1;
      m_ph = 1'b1;
    end else begin
      e_vs = v && m_pv && !s[3];
      e_hs = v && m_ph && !s[1];
      if (v) begin
        m_pv = s[3];
        m_ph = s[1];
      end
    end
    @(posedge VCLK);
    #1;
  endtask

  task automatic gen_step();
    logic nv, nh, v;
    int   col;
    col = gpos % LINE;
    nh  = hs_on ? (col >= 2) : 1'b1;
    nv  = vs_on ? !((gpos >= 5) && (gpos < 15)) : 1'b1;
    v   = vmode ? ((gpos % 4) != 1) : 1'b1;
    gpos = (gpos + 1) % FIELD;
    drive(v, {nv, 1'b1, nh, 1'b1});
  endtask

  task automatic run_to_pos(input int p);
    int n;
    n = 0;
    while ((gpos != p) && (n < FIELD)) begin
      gen_step();
      n++;
    end
  endtask

  task automatic run_until_vs(input string name);
    int n;
    n = 0;
    e_vs = 1'b0;
    do begin
      gen_step();
      n++;
    end while (!e_vs && (n < 1000));
    if (!e_vs) bound_fail(name);
  endtask

  initial begin
    int n;
    int k;

    RST = 1'b1;
    palmode = 1'b0;
    tp_req = 1'b0;
    vdata_sync_valid_i = 1'b0;
    vdata_sync_i = 4'hF;

    // ---- Reset held 3 cycles, then 5 quiet NTSC fields ----
    for (int i = 0; i < 3; i++) begin
      gen_step();
      chk("reset_hold", 4'b0000);
    end
    RST = 1'b0;
    gen_step();
    chk("reset_state", 4'b0000);
    for (int i = 1; i < 5 * FIELD; i++) begin
      gen_step();
      chk("idle_fields", 4'b0000);
    end

    // ---- Table: hand-timed sync edges (F = all high, 7 = nVSYNC low) ----
    tbl[0]  = mk(1'b1, 4'hF, 1'b0, 4'b0000);
    tbl[1]  = mk(1'b1, 4'hF, 1'b1, 4'b0010);  // request -> ARM
    tbl[2]  = mk(1'b1, 4'h7, 1'b1, 4'b0110);  // vs_fall -> BLANK
    tbl[3]  = mk(1'b1, 4'hF, 1'b1, 4'b0110);
    tbl[4]  = mk(1'b0, 4'h7, 1'b1, 4'b0110);  // invalid: no edge
    tbl[5]  = mk(1'b1, 4'h7, 1'b1, 4'b0110);  // edge seen late, fcnt 2->1
    tbl[6]  = mk(1'b1, 4'hF, 1'b1, 4'b0110);
    tbl[7]  = mk(1'b1, 4'h7, 1'b1, 4'b1000);  // last field: toggle + unblank
    tbl[8]  = mk(1'b1, 4'hF, 1'b1, 4'b1000);
    tbl[9]  = mk(1'b1, 4'hF, 1'b0, 4'b1010);  // request back -> ARM
    tbl[10] = mk(1'b1, 4'hF, 1'b1, 4'b1000);  // cancel
    tbl[11] = mk(1'b1, 4'hF, 1'b0, 4'b1010);
    tbl[12] = mk(1'b1, 4'h7, 1'b0, 4'b1110);  // BLANK
    tbl[13] = mk(1'b1, 4'hF, 1'b1, 4'b1110);  // revert during BLANK
    tbl[14] = mk(1'b1, 4'h7, 1'b1, 4'b1110);
    tbl[15] = mk(1'b1, 4'hF, 1'b1, 4'b1110);
    tbl[16] = mk(1'b1, 4'h7, 1'b1, 4'b1000);  // blank ends, no toggle
    tbl[17] = mk(1'b1, 4'hF, 1'b0, 4'b1010);
    tbl[18] = mk(1'b1, 4'h7, 1'b0, 4'b1110);
    tbl[19] = mk(1'b1, 4'hF, 1'b0, 4'b1110);
    tbl[20] = mk(1'b1, 4'h7, 1'b0, 4'b1110);
    tbl[21] = mk(1'b1, 4'hF, 1'b0, 4'b1110);
    tbl[22] = mk(1'b1, 4'h7, 1'b0, 4'b0000);  // back to live video
    for (int i = 0; i < 23; i++) begin
      tp_req = tbl[i].req;
      drive(tbl[i].v, tbl[i].s);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // ---- Normal switch with generated NTSC sync, and back ----
    run_to_pos(60);
    tp_req = 1'b1;
    gen_step();
    chk("sw_busy", 4'b0010);
    run_until_vs("sw_vs1");
    chk("sw_blank_start", 4'b0110);
    run_until_vs("sw_vs2");
    chk("sw_blank_mid", 4'b0110);
    run_until_vs("sw_vs3");
    chk("sw_done", 4'b1000);

    run_to_pos(60);
    tp_req = 1'b0;
    gen_step();
    chk("back_busy", 4'b1010);
    run_until_vs("back_vs1");
    chk("back_blank_start", 4'b1110);
    run_until_vs("back_vs2");
    chk("back_blank_mid", 4'b1110);
    run_until_vs("back_vs3");
    chk("back_done", 4'b0000);

    // ---- Cancel in ARM ----
    run_to_pos(60);
    tp_req = 1'b1;
    gen_step();
    chk("cancel_arm", 4'b0010);
    for (int i = 0; i < 3; i++) gen_step();
    chk("cancel_wait", 4'b0010);
    tp_req = 1'b0;
    gen_step();
    chk("cancel_drop", 4'b0000);
    run_until_vs("cancel_vs");
    chk("cancel_no_blank", 4'b0000);

    // ---- Line-count sync loss (PAL threshold) while blanking ----
    palmode = 1'b1;
    run_to_pos(60);
    tp_req = 1'b1;
    gen_step();
    chk("loss_arm", 4'b0010);
    run_until_vs("loss_vs");
    chk("loss_blank", 4'b0110);
    vs_on = 1'b0;
    n = 0;
    k = 0;
    while ((n < 330) && (k < 5000)) begin
      gen_step();
      k++;
      if (e_hs) begin
        n++;
        if (n == 280) chk("loss_ntsc_thr_ignored", 4'b0110);
        if (n == 329) chk("loss_pre", 4'b0110);
      end
    end
    if (n < 330) bound_fail("loss_lines");
    chk("loss_set", 4'b0111);
    gen_step();
    chk("loss_switch", 4'b1001);
    run_to_pos(20);
    chk("loss_hold", 4'b1001);
    vs_on = 1'b1;
    run_until_vs("loss_restore");
    chk("loss_clear", 4'b1000);

    // ---- Cycle timeout with 1-in-4 invalid cycles ----
    n = 0;
    e_hs = 1'b0;
    while (!e_hs && (n < 20)) begin
      gen_step();
      n++;
    end
    if (!e_hs) bound_fail("cyc_hs_sync");
    hs_on = 1'b0;
    vs_on = 1'b0;
    vmode = 1'b1;
    for (int i = 1; i <= 8191; i++) begin
      gen_step();
      if (i == 8190) chk("cyc_pre", 4'b1000);
    end
    chk("cyc_timeout", 4'b1001);
    gpos  = 0;
    hs_on = 1'b1;
    vs_on = 1'b1;
    run_until_vs("cyc_restore");
    chk("cyc_clear_interleaved", 4'b1000);
    vmode = 1'b0;

    // ---- Reset in the middle of a switch ----
    run_to_pos(60);
    tp_req = 1'b0;
    gen_step();
    chk("rst_mid_arm", 4'b1010);
    run_until_vs("rst_mid_vs");
    chk("rst_mid_blank", 4'b1110);
    RST = 1'b1;
    gen_step();
    chk("rst_mid_reset", 4'b0000);
    RST = 1'b0;
    gen_step();
    chk("rst_mid_after", 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
